// File: rtl/multicycle_proc_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_proc_controller_if
//
// Bundles the controller's instruction/data memory handshake and datapath
// control signals.
//
//   master : the controller side. It receives opcode, imem_ready and
//            dmem_ready, and drives every strobe and control field.
//   slave  : the datapath and memory side. It is the mirror of master.
//
// Signals:
//   opcode       opcode field of the fetched word (valid with imem_ready)
//   imem_ready   instruction memory returns data this cycle
//   dmem_ready   data memory access completes this cycle
//   imem_req     instruction fetch request
//   dmem_req     data memory request
//   mem_write    data request is a store
//   ir_write     load IR
//   pc_write     update PC
//   alu_control  ALU operation
//   alusrc       ALU operand B is the immediate
//   mem_to_reg   writeback data comes from memory
//   branch       conditional branch evaluation
//   jal          jump-and-link
//   reg_write    register file write enable
//   retire       one-cycle pulse when an instruction completes
//   mem_fault    sticky memory-timeout fault
// ---------------------------------------------------------------------------
interface multicycle_proc_controller_if #(
    parameter int OPCODE_WIDTH   = 8,
    parameter int ALU_CTRL_WIDTH = 8
);
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic                      imem_ready;
    logic                      dmem_ready;
    logic                      imem_req;
    logic                      dmem_req;
    logic                      mem_write;
    logic                      ir_write;
    logic                      pc_write;
    logic [ALU_CTRL_WIDTH-1:0] alu_control;
    logic                      alusrc;
    logic                      mem_to_reg;
    logic                      branch;
    logic                      jal;
    logic                      reg_write;
    logic                      retire;
    logic                      mem_fault;

    modport master (
        input  opcode, imem_ready, dmem_ready,
        output imem_req, dmem_req, mem_write, ir_write, pc_write,
               alu_control, alusrc, mem_to_reg, branch, jal,
               reg_write, retire, mem_fault
    );

    modport slave (
        output opcode, imem_ready, dmem_ready,
        input  imem_req, dmem_req, mem_write, ir_write, pc_write,
               alu_control, alusrc, mem_to_reg, branch, jal,
               reg_write, retire, mem_fault
    );
endinterface

// File: rtl/multicycle_proc_controller.sv
// ---------------------------------------------------------------------------
// multicycle_proc_controller
//
// This is the multi-cycle instruction sequencer. It steps each instruction
// through the FETCH, DECODE, EXEC, MEM and WB states. It waits on the
// instruction and data memory handshakes for as long as they take. If a
// handshake stalls past MEM_TIMEOUT cycles, the controller traps into a
// sticky FAULT state.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous, active-low reset
//   bus      controller side (master) of multicycle_proc_controller_if
//
// Opcode classes are decoded from the latched opcode, in priority order:
//   op[4]&op[5] JAL, op[4]&op[6] SW, op[4] LW, op[7] ALUI/CMPI,
//   op[6] BCOND, otherwise ALUR/CMPR.
// ---------------------------------------------------------------------------
module multicycle_proc_controller #(
    parameter int OPCODE_WIDTH   = 8,
    parameter int ALU_CTRL_WIDTH = 8,
    parameter int MEM_TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         reset_n,
    multicycle_proc_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_ALUR,
        C_ALUI,
        C_BCOND,
        C_LW,
        C_SW,
        C_JAL
    } iclass_t;

    // The counter only needs to reach MEM_TIMEOUT. With the timeout
    // disabled it is a single unused bit.
    localparam int               CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam bit               TIMEOUT_EN = (MEM_TIMEOUT > 0);

    state_t                  state, state_n;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    cnt_inc;
    logic                    timeout_hit;
    iclass_t                 iclass;

    // Ungated control values. Everything is forced low while reset_n is
    // low, so an instruction aborted by reset cannot fire a strobe on
    // the reset edge.
    logic                      imem_req_c, dmem_req_c, mem_write_c, ir_write_c;
    logic                      pc_write_c, alusrc_c, mem_to_reg_c, branch_c;
    logic                      jal_c, reg_write_c, retire_c, mem_fault_c;
    logic [ALU_CTRL_WIDTH-1:0] alu_control_c;

    // ---------------------------------------------------------------
    // Instruction class decode from the latched opcode
    // ---------------------------------------------------------------
    always_comb begin
        if (op_q[4] && op_q[5])      iclass = C_JAL;
        else if (op_q[4] && op_q[6]) iclass = C_SW;
        else if (op_q[4])            iclass = C_LW;
        else if (op_q[7])            iclass = C_ALUI;
        else if (op_q[6])            iclass = C_BCOND;
        else                         iclass = C_ALUR;
    end

    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LIMIT);

    // ---------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default here
        // first. That way no path leaves a value held over, and no latch
        // is inferred.
        state_n       = state;
        cnt_inc       = 1'b0;
        imem_req_c    = 1'b0;
        dmem_req_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        alusrc_c      = 1'b0;
        mem_to_reg_c  = 1'b0;
        branch_c      = 1'b0;
        jal_c         = 1'b0;
        reg_write_c   = 1'b0;
        retire_c      = 1'b0;
        mem_fault_c   = 1'b0;
        alu_control_c = '0;

        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                // Ready wins over a timeout reached in the same cycle.
                if (bus.imem_ready) begin
                    ir_write_c = 1'b1;
                    state_n    = S_DECODE;
                end else if (timeout_hit) begin
                    state_n = S_FAULT;
                end else begin
                    cnt_inc = TIMEOUT_EN;
                end
            end

            S_DECODE: begin
                state_n = S_EXEC;
            end

            S_EXEC: begin
                alu_control_c = op_q[ALU_CTRL_WIDTH-1:0];
                alusrc_c      = (iclass != C_ALUR) && (iclass != C_BCOND);
                case (iclass)
                    C_BCOND: begin
                        branch_c   = 1'b1;
                        pc_write_c = 1'b1;
                        retire_c   = 1'b1;
                        state_n    = S_FETCH;
                    end
                    C_LW, C_SW: state_n = S_MEM;
                    default:    state_n = S_WB;
                endcase
            end

            S_MEM: begin
                dmem_req_c    = 1'b1;
                alusrc_c      = 1'b1;
                alu_control_c = op_q[ALU_CTRL_WIDTH-1:0];
                mem_write_c   = (iclass == C_SW);
                if (bus.dmem_ready) begin
                    if (iclass == C_SW) begin
                        pc_write_c = 1'b1;
                        retire_c   = 1'b1;
                        state_n    = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_n = S_FAULT;
                end else begin
                    cnt_inc = TIMEOUT_EN;
                end
            end

            S_WB: begin
                reg_write_c  = 1'b1;
                pc_write_c   = 1'b1;
                retire_c     = 1'b1;
                mem_to_reg_c = (iclass == C_LW);
                jal_c        = (iclass == C_JAL);
                state_n      = S_FETCH;
            end

            S_FAULT: begin
                mem_fault_c = 1'b1;
            end

            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State, latched opcode and wait counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples the values from before the edge.
        if (!reset_n) begin
            state    <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            if (ir_write_c) begin
                op_q <= bus.opcode;
            end
            if (state_n != state) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs, all held low during reset
    // ---------------------------------------------------------------
    assign bus.imem_req    = reset_n & imem_req_c;
    assign bus.dmem_req    = reset_n & dmem_req_c;
    assign bus.mem_write   = reset_n & mem_write_c;
    assign bus.ir_write    = reset_n & ir_write_c;
    assign bus.pc_write    = reset_n & pc_write_c;
    assign bus.alusrc      = reset_n & alusrc_c;
    assign bus.mem_to_reg  = reset_n & mem_to_reg_c;
    assign bus.branch      = reset_n & branch_c;
    assign bus.jal         = reset_n & jal_c;
    assign bus.reg_write   = reset_n & reg_write_c;
    assign bus.retire      = reset_n & retire_c;
    assign bus.mem_fault   = reset_n & mem_fault_c;
    assign bus.alu_control = reset_n ? alu_control_c : '0;

endmodule

// File: tb/tb_multicycle_proc_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_proc_controller
//
// Directed bench for multicycle_proc_controller. Each scenario walks the
// controller one cycle at a time through a table of rows. Each row holds:
//   - the reset value for that cycle,
//   - the imem_ready and dmem_ready values for that cycle,
//   - the expected output word: the 12 control flags followed by
//     alu_control.
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// 2 time units later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_multicycle_proc_controller;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    multicycle_proc_controller_if #(.OPCODE_WIDTH(8), .ALU_CTRL_WIDTH(8)) bus ();

    multicycle_proc_controller #(
        .OPCODE_WIDTH  (8),
        .ALU_CTRL_WIDTH(8),
        .MEM_TIMEOUT   (15)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    // Flag positions in the 12-bit control word.
    localparam logic [11:0] IMREQ = 12'h800;
    localparam logic [11:0] DMREQ = 12'h400;
    localparam logic [11:0] MW    = 12'h200;
    localparam logic [11:0] IRW   = 12'h100;
    localparam logic [11:0] PCW   = 12'h080;
    localparam logic [11:0] ASRC  = 12'h040;
    localparam logic [11:0] M2R   = 12'h020;
    localparam logic [11:0] BR    = 12'h010;
    localparam logic [11:0] JL    = 12'h008;
    localparam logic [11:0] RW    = 12'h004;
    localparam logic [11:0] RET   = 12'h002;
    localparam logic [11:0] FLT   = 12'h001;
    localparam logic [11:0] NONE  = 12'h000;

    typedef struct {
        logic        rst;
        logic        im;
        logic        dm;
        logic [19:0] exp;
    } row_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [19:0] obs();
        return {bus.imem_req, bus.dmem_req, bus.mem_write, bus.ir_write,
                bus.pc_write, bus.alusrc, bus.mem_to_reg, bus.branch,
                bus.jal, bus.reg_write, bus.retire, bus.mem_fault,
                bus.alu_control};
    endfunction

    function automatic row_t mk(logic rst, logic im, logic dm,
                                logic [11:0] flags, logic [7:0] alu);
        row_t r;
        r.rst = rst;
        r.im  = im;
        r.dm  = dm;
        r.exp = {flags, alu};
        return r;
    endfunction

    // Hold reset for two edges. On return, reset_n is still low and the
    // controller sits in FETCH.
    task automatic apply_reset();
        reset_n        = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        apply_reset();
        bus.opcode = 8'h00;
        // Ready inputs high while in reset: every output must stay low.
        rows.push_back(mk(1'b0, 1'b1, 1'b1, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alur();
        row_t rows[$];
        apply_reset();
        bus.opcode = 8'h00;
        // Two back-to-back ALUR instructions: retire every 4 cycles.
        for (int k = 0; k < 2; k++) begin
            rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
            rows.push_back(mk(1'b1, 1'b1, 1'b0, NONE, 8'h00));
            rows.push_back(mk(1'b1, 1'b1, 1'b0, NONE, 8'h00));
            rows.push_back(mk(1'b1, 1'b1, 1'b0, RW | PCW | RET, 8'h00));
        end
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL alur cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_ops();
        row_t rows[$];
        apply_reset();
        // ALUR 8'h0B: alu_control follows the opcode and alusrc stays low.
        bus.opcode = 8'h0B;
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h0B));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, RW | PCW | RET, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL alur_0b cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
        // ALUI 8'h85 (op[7] set, op[4] clear): alusrc is high in EXEC.
        rows.delete();
        bus.opcode = 8'h85;
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, ASRC, 8'h85));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, RW | PCW | RET, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL alui cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        row_t rows[$];
        apply_reset();
        bus.opcode = 8'h10;
        // dmem_ready arrives on the 4th MEM cycle. retire lands in the 8th
        // cycle, counting the first imem_req cycle as cycle 1.
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, ASRC, 8'h10));
        for (int k = 0; k < 3; k++)
            rows.push_back(mk(1'b1, 1'b1, 1'b0, DMREQ | ASRC, 8'h10));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, DMREQ | ASRC, 8'h10));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, RW | PCW | RET | M2R, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_jal_bcond();
        row_t rows[$];
        // SW 8'h50: stores and retires from MEM, never writes a register.
        apply_reset();
        bus.opcode = 8'h50;
        rows.push_back(mk(1'b1, 1'b1, 1'b1, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, ASRC, 8'h50));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, DMREQ | MW | ASRC | PCW | RET, 8'h50));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, IMREQ | IRW, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL sw cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
        // JAL 8'h30: alusrc in EXEC, and WB carries jal.
        rows.delete();
        apply_reset();
        bus.opcode = 8'h30;
        rows.push_back(mk(1'b1, 1'b1, 1'b1, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, ASRC, 8'h30));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, RW | PCW | RET | JL, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL jal cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
        // BCOND 8'h40: retires from EXEC on cycle 3, with no reg_write.
        rows.delete();
        apply_reset();
        bus.opcode = 8'h40;
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, BR | PCW | RET, 8'h40));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL bcond cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        // Fetch stall: 16 waiting cycles, then FAULT. The fault sticks even
        // when ready rises afterwards.
        apply_reset();
        bus.opcode = 8'h00;
        for (int k = 0; k < 16; k++)
            rows.push_back(mk(1'b1, 1'b0, 1'b0, IMREQ, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, FLT, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, FLT, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, FLT, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL fetch_timeout cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
        // Ready in the 16th wait cycle: the fetch completes and no fault
        // is raised.
        rows.delete();
        apply_reset();
        for (int k = 0; k < 15; k++)
            rows.push_back(mk(1'b1, 1'b0, 1'b0, IMREQ, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, RW | PCW | RET, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL ready_at_limit cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
        // Data stall on an LW. The counter restarts on entering MEM, so
        // there are 16 MEM wait cycles before FAULT.
        rows.delete();
        apply_reset();
        bus.opcode = 8'h10;
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, ASRC, 8'h10));
        for (int k = 0; k < 16; k++)
            rows.push_back(mk(1'b1, 1'b0, 1'b0, DMREQ | ASRC, 8'h10));
        rows.push_back(mk(1'b1, 1'b0, 1'b1, FLT, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL mem_timeout cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        row_t rows[$];
        apply_reset();
        bus.opcode = 8'h10;
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, ASRC, 8'h10));
        // Reset in MEM with dmem_ready high: no strobes, and the LW aborts.
        rows.push_back(mk(1'b0, 1'b0, 1'b1, NONE, 8'h00));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, NONE, 8'h00));
        // Released: the controller is in FETCH again, not in WB.
        rows.push_back(mk(1'b1, 1'b1, 1'b0, IMREQ | IRW, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, NONE, 8'h00));
        foreach (rows[i]) begin
            reset_n = rows[i].rst; bus.imem_ready = rows[i].im; bus.dmem_ready = rows[i].dm;
            #2;
            n_checks++;
            if (obs() !== rows[i].exp) begin
                n_fail++;
                $display("FAIL reset_mid_mem cycle %0d: got %h expected %h", i, obs(), rows[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.opcode     = 8'h00;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        #1;
        test_reset();
        test_alur();
        test_alu_ops();
        test_lw_wait();
        test_sw_jal_bcond();
        test_timeout();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_proc_controller.md
Name: multicycle_proc_controller

Overview:
- Multi-cycle successor to the single-cycle processor controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using the same opcode class encoding.
- Handshakes with instruction and data memories that may take several cycles, and raises a fault on memory timeout.
- Sits between the IR/PC datapath and the memory interfaces of the multi-cycle processor.

Parameters:
- OPCODE_WIDTH, 8, opcode width; must be >= 8. Class bits are opcode[4..7].
- ALU_CTRL_WIDTH, 8, width of alu_control; equals the low ALU_CTRL_WIDTH bits of the latched opcode.
- MEM_TIMEOUT, 15, maximum wait cycles on a memory handshake before fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  OPCODE_WIDTH  opcode field of the fetched instruction word; valid in the cycle that imem_ready is high.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- mem_write  out  1  data request is a store.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC (PC+4, branch target or jump target, selected by datapath).
- alu_control  out  ALU_CTRL_WIDTH  ALU operation.
- alusrc  out  1  ALU operand B = immediate.
- mem_to_reg  out  1  writeback data from memory.
- branch  out  1  conditional branch evaluation.
- jal  out  1  jump-and-link.
- reg_write  out  1  register file write enable.
- retire  out  1  one-cycle pulse on instruction completion.
- mem_fault  out  1  sticky timeout fault.

Behaviour:
- Only clk is used. Reset is sampled on the rising edge; reset_n low forces the state to FETCH, clears the latched opcode and wait counter, and clears mem_fault.
- All outputs are 0 while reset_n is low. imem_req rises in the first cycle after reset_n goes high.
- Reset asserted mid-instruction aborts the instruction; no write strobe fires on that edge.
- Class decode uses the latched opcode, in priority order:
  - op[4]&op[5] = JAL
  - op[4]&op[6] = SW
  - op[4] = LW
  - op[7] = ALUI/CMPI
  - op[6] = BCOND
  - else ALUR/CMPR
- States and transitions:
  - FETCH: imem_req=1.
    - imem_ready=1: ir_write=1, opcode latched, go to DECODE.
    - Else stay and increment the wait counter.
  - DECODE: no strobes; operand read. Go to EXEC.
  - EXEC: alu_control driven; alusrc=1 for ALUI/CMPI/LW/SW/JAL.
    - BCOND: branch=1, pc_write=1, retire=1, go to FETCH.
    - LW/SW: go to MEM.
    - All others: go to WB.
  - MEM: dmem_req=1, alusrc=1, alu_control held; mem_write=1 for SW.
    - dmem_ready=1, SW: pc_write=1, retire=1, go to FETCH.
    - dmem_ready=1, LW: go to WB.
    - Else stay and increment the wait counter.
  - WB: reg_write=1, pc_write=1, retire=1. mem_to_reg=1 for LW; jal=1 for JAL. Go to FETCH.
  - FAULT: mem_fault=1; all other outputs 0. Exit only via reset.
- Wait counter:
  - Clears on every state transition.
  - In FETCH/MEM with ready low and MEM_TIMEOUT>0: when the counter equals MEM_TIMEOUT, the next edge enters FAULT.
  - Ready arriving in the same cycle as the limit wins; the access completes normally.
- Latency with zero-wait memory (ready high on the first request cycle):
  - ALUR/ALUI/CMP: 4 cycles.
  - JAL: 4 cycles.
  - BCOND: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- alu_control, alusrc, mem_to_reg and jal are stable for the whole state; strobes are single-cycle.

Test Plan:
- ALUR opcode 8'h00 with imem_ready tied 1 -> states FETCH, DECODE, EXEC, WB. In WB: reg_write=1, pc_write=1, retire=1. retire recurs every 4 cycles.
- LW opcode 8'h10 with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with mem_write=0. In WB: mem_to_reg=1, reg_write=1. retire 8 cycles after the first imem_req.
- SW 8'h50 and JAL 8'h30 -> SW: mem_write=1 in MEM, reg_write never asserted. JAL: WB with jal=1, alusrc=1 in EXEC, reg_write=1.
- BCOND 8'h40 -> branch=1 and pc_write=1 in EXEC, retire on cycle 3, no reg_write.
- MEM_TIMEOUT=15, imem_ready held 0 -> FAULT entered after 16 waiting cycles; mem_fault stays 1. Ready asserted in the 16th wait cycle instead -> no fault.
- reset_n low during MEM of an LW with dmem_ready=1 -> no reg_write and no retire. State is FETCH and outputs are 0 next cycle; imem_req returns after reset_n rises.
